// File: rtl/lc3_isdu.sv
// lc3_isdu: LC-3 instruction sequencing/decode Moore FSM.
// Control outputs are registered from the next state, so they change only with the state.
module lc3_isdu #(
  parameter int MEM_WAIT = 2,
  parameter int CNT_W    = 2
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run,
  input  logic       Continue,
  input  logic [3:0] Opcode,
  input  logic       IR_5,
  input  logic       IR_11,
  input  logic       BEN,
  output logic       LD_MAR,
  output logic       LD_MDR,
  output logic       LD_IR,
  output logic       LD_BEN,
  output logic       LD_CC,
  output logic       LD_REG,
  output logic       LD_PC,
  output logic       LD_LED,
  output logic       GatePC,
  output logic       GateMDR,
  output logic       GateALU,
  output logic       GateMARMUX,
  output logic [1:0] PCMUX,
  output logic       DRMUX,
  output logic       SR1MUX,
  output logic       SR2MUX,
  output logic       ADDR1MUX,
  output logic [1:0] ADDR2MUX,
  output logic [1:0] ALUK,
  output logic       Mem_OE,
  output logic       Mem_WE
);
  typedef enum logic [4:0] {
    HALTED, S18, S33, S35, S32, S01, S05, S09, S00, S22, S12,
    S04, S21, S20, S06, S25, S27, S07, S23, S16, PAUSE1, PAUSE2
  } state_t;
  typedef struct packed {
    logic       ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
    logic       g_pc, g_mdr, g_alu, g_marmux;
    logic [1:0] pcmux;
    logic       drmux, sr1mux, sr2mux, addr1mux;
    logic [1:0] addr2mux, aluk;
    logic       oe, we;
  } ctl_t;
  state_t           r_state, w_next;
  logic [CNT_W-1:0] r_cnt;
  ctl_t             r_ctl;
  logic             w_wait, w_done;
  assign w_wait = r_state inside {S33, S25, S16};
  assign w_done = r_cnt == CNT_W'(MEM_WAIT - 1);
  always_comb begin
    w_next = r_state;
    case (r_state)
      HALTED: w_next = Run ? S18 : HALTED;
      S18:    w_next = S33;
      S33:    w_next = w_done ? S35 : S33;
      S35:    w_next = S32;
      S32:
        case (Opcode)
          4'b0001: w_next = S01;
          4'b0101: w_next = S05;
          4'b1001: w_next = S09;
          4'b0000: w_next = S00;
          4'b1100: w_next = S12;
          4'b0100: w_next = S04;
          4'b0110: w_next = S06;
          4'b0111: w_next = S07;
          4'b1101: w_next = PAUSE1;
          default: w_next = S18;
        endcase
      S00:    w_next = BEN ? S22 : S18;
      S04:    w_next = IR_11 ? S21 : S20;
      S06:    w_next = S25;
      S25:    w_next = w_done ? S27 : S25;
      S07:    w_next = S23;
      S23:    w_next = S16;
      S16:    w_next = w_done ? S18 : S16;
      PAUSE1: w_next = Continue ? PAUSE2 : PAUSE1;
      PAUSE2: w_next = Continue ? PAUSE2 : S18;
      S01, S05, S09, S22, S12, S21, S20, S27: w_next = S18;
      default: w_next = HALTED;
    endcase
  end
  function automatic ctl_t decode(input state_t s, input logic ir5);
    ctl_t c;
    c = '0;
    case (s)
      S18: begin c.ld_mar = 1'b1; c.g_pc = 1'b1; c.ld_pc = 1'b1; end
      S33: c.oe = 1'b1;
      S35: begin c.g_mdr = 1'b1; c.ld_ir = 1'b1; end
      S32: c.ld_ben = 1'b1;
      S01, S05: begin
        c.sr1mux = 1'b1; c.sr2mux = ir5; c.aluk = (s == S05) ? 2'b01 : 2'b00;
        c.g_alu = 1'b1; c.ld_reg = 1'b1; c.ld_cc = 1'b1;
      end
      S09: begin
        c.sr1mux = 1'b1; c.aluk = 2'b10; c.g_alu = 1'b1; c.ld_reg = 1'b1; c.ld_cc = 1'b1;
      end
      S22: begin c.addr2mux = 2'b10; c.pcmux = 2'b10; c.ld_pc = 1'b1; end
      S12, S20: begin c.sr1mux = 1'b1; c.addr1mux = 1'b1; c.pcmux = 2'b10; c.ld_pc = 1'b1; end
      S04: begin c.g_pc = 1'b1; c.drmux = 1'b1; c.ld_reg = 1'b1; end
      S21: begin c.addr2mux = 2'b11; c.pcmux = 2'b10; c.ld_pc = 1'b1; end
      S06, S07: begin
        c.sr1mux = 1'b1; c.addr1mux = 1'b1; c.addr2mux = 2'b01; c.g_marmux = 1'b1; c.ld_mar = 1'b1;
      end
      S25: begin c.oe = 1'b1; c.ld_mdr = 1'b1; end
      S27: begin c.g_mdr = 1'b1; c.ld_reg = 1'b1; c.ld_cc = 1'b1; end
      S23: begin c.aluk = 2'b11; c.g_alu = 1'b1; c.ld_mdr = 1'b1; end
      S16: c.we = 1'b1;
      PAUSE1: c.ld_led = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction
  // wait counter is zero outside the memory states, so it is clear on every entry
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= HALTED;
      r_cnt   <= '0;
      r_ctl   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (w_wait && !w_done) ? r_cnt + 1'b1 : '0;
      r_ctl   <= decode(w_next, IR_5);
    end
  end
  assign {LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
          GatePC, GateMDR, GateALU, GateMARMUX, PCMUX, DRMUX, SR1MUX, SR2MUX,
          ADDR1MUX, ADDR2MUX, ALUK, Mem_OE, Mem_WE} = r_ctl;
endmodule

// File: tb/tb_lc3_isdu.sv
// tb_lc3_isdu: random instruction streams checked cycle by cycle against
// per-instruction micro-op sequences built from the LC-3 control rules.
module tb_lc3_isdu;
  localparam int W = 2;
  logic Clk = 1'b0, Reset = 1'b1, Run = 1'b0, Continue = 1'b0;
  logic [3:0] Opcode = 4'd0;
  logic IR_5 = 1'b0, IR_11 = 1'b0, BEN = 1'b0;
  logic LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
  logic GatePC, GateMDR, GateALU, GateMARMUX, DRMUX, SR1MUX, SR2MUX, ADDR1MUX;
  logic [1:0] PCMUX, ADDR2MUX, ALUK;
  logic Mem_OE, Mem_WE;
  typedef struct packed {
    logic       ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
    logic       g_pc, g_mdr, g_alu, g_marmux;
    logic [1:0] pcmux;
    logic       drmux, sr1mux, sr2mux, addr1mux;
    logic [1:0] addr2mux, aluk;
    logic       oe, we;
  } ov_t;
  ov_t obs;
  int n_chk = 0, n_fail = 0;
  lc3_isdu #(.MEM_WAIT(W), .CNT_W(2)) dut (
    .Clk(Clk), .Reset(Reset), .Run(Run), .Continue(Continue), .Opcode(Opcode),
    .IR_5(IR_5), .IR_11(IR_11), .BEN(BEN),
    .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_BEN(LD_BEN), .LD_CC(LD_CC),
    .LD_REG(LD_REG), .LD_PC(LD_PC), .LD_LED(LD_LED),
    .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU), .GateMARMUX(GateMARMUX),
    .PCMUX(PCMUX), .DRMUX(DRMUX), .SR1MUX(SR1MUX), .SR2MUX(SR2MUX),
    .ADDR1MUX(ADDR1MUX), .ADDR2MUX(ADDR2MUX), .ALUK(ALUK),
    .Mem_OE(Mem_OE), .Mem_WE(Mem_WE)
  );
  assign obs = {LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
                GatePC, GateMDR, GateALU, GateMARMUX, PCMUX, DRMUX, SR1MUX, SR2MUX,
                ADDR1MUX, ADDR2MUX, ALUK, Mem_OE, Mem_WE};
  always #5 Clk = ~Clk;
  task automatic check(input string tag, input logic [23:0] got, input logic [23:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  // expected control word for each named micro-step of an instruction
  function automatic ov_t uop(input string s, input logic ir5);
    ov_t e;
    e = '0;
    case (s)
      "S18":   begin e.ld_mar = 1; e.g_pc = 1; e.ld_pc = 1; end
      "OE":    e.oe = 1;
      "S35":   begin e.g_mdr = 1; e.ld_ir = 1; end
      "S32":   e.ld_ben = 1;
      "ADD":   begin e.sr1mux = 1; e.sr2mux = ir5; e.g_alu = 1; e.ld_reg = 1; e.ld_cc = 1; end
      "AND":   begin e.sr1mux = 1; e.sr2mux = ir5; e.aluk = 2'b01; e.g_alu = 1; e.ld_reg = 1; e.ld_cc = 1; end
      "NOT":   begin e.sr1mux = 1; e.aluk = 2'b10; e.g_alu = 1; e.ld_reg = 1; e.ld_cc = 1; end
      "BR":    begin e.addr2mux = 2'b10; e.pcmux = 2'b10; e.ld_pc = 1; end
      "JMP":   begin e.sr1mux = 1; e.addr1mux = 1; e.pcmux = 2'b10; e.ld_pc = 1; end
      "JSR4":  begin e.g_pc = 1; e.drmux = 1; e.ld_reg = 1; end
      "JSR21": begin e.addr2mux = 2'b11; e.pcmux = 2'b10; e.ld_pc = 1; end
      "ADR":   begin e.sr1mux = 1; e.addr1mux = 1; e.addr2mux = 2'b01; e.g_marmux = 1; e.ld_mar = 1; end
      "RD":    begin e.oe = 1; e.ld_mdr = 1; end
      "LDR":   begin e.g_mdr = 1; e.ld_reg = 1; e.ld_cc = 1; end
      "STR":   begin e.aluk = 2'b11; e.g_alu = 1; e.ld_mdr = 1; end
      "WE":    e.we = 1;
      "LED":   e.ld_led = 1;
      default: e = '0;
    endcase
    return e;
  endfunction
  task automatic tick(input string s);
    @(posedge Clk);
    #1;
    check(s, obs, uop(s, IR_5));
    check("one_gate", 24'(($countones({GatePC, GateMDR, GateALU, GateMARMUX}) <= 1)), 24'd1);
  endtask
  // called while the FSM sits in S18 (already checked); ends after the next S18 is checked
  task automatic run_instr(input logic [3:0] op, input logic ir5, input logic ir11,
                           input logic ben, input int k, input int m);
    string q[$];
    Opcode = op; IR_5 = ir5; IR_11 = ir11; BEN = ben; Continue = 1'b0;
    repeat (W) tick("OE");
    tick("S35");
    tick("S32");
    case (op)
      4'b0001: q.push_back("ADD");
      4'b0101: q.push_back("AND");
      4'b1001: q.push_back("NOT");
      4'b0000: begin q.push_back("Z"); if (ben) q.push_back("BR"); end
      4'b1100: q.push_back("JMP");
      4'b0100: begin q.push_back("JSR4"); q.push_back(ir11 ? "JSR21" : "JMP"); end
      4'b0110: begin q.push_back("ADR"); repeat (W) q.push_back("RD"); q.push_back("LDR"); end
      4'b0111: begin q.push_back("ADR"); q.push_back("STR"); repeat (W) q.push_back("WE"); end
      4'b1101: begin
        repeat (k + 1) tick("LED");
        Continue = 1'b1;
        repeat (m) tick("Z");
        Continue = 1'b0;
      end
      default: ;
    endcase
    foreach (q[i]) tick(q[i]);
    tick("S18");
  endtask
  initial begin
    repeat (2) @(posedge Clk);
    #1;
    check("reset", obs, 24'd0);
    Reset = 1'b0;
    Run = 1'b1;
    tick("S18");
    tick("OE");
    #2 Reset = 1'b1;
    #1 check("async_reset", obs, 24'd0);
    @(posedge Clk);
    #1;
    Run = 1'b0;
    Reset = 1'b0;
    repeat (10) tick("Z");
    Run = 1'b1;
    tick("S18");
    Run = 1'b0;
    run_instr(4'b0000, 0, 0, 1, 0, 0);
    run_instr(4'b0000, 0, 0, 0, 0, 0);
    run_instr(4'b0001, 1, 0, 0, 0, 0);
    run_instr(4'b0111, 0, 0, 0, 0, 0);
    run_instr(4'b0110, 0, 0, 0, 0, 0);
    run_instr(4'b1101, 0, 0, 0, 3, 5);
    run_instr(4'b0100, 0, 1, 0, 0, 0);
    run_instr(4'b0100, 0, 0, 0, 0, 0);
    run_instr(4'b1111, 0, 0, 0, 0, 0);
    repeat (120)
      run_instr(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), int'($urandom_range(1, 5)));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule

// File: doc/lc3_isdu.md
Name: lc3_isdu

Overview:
- Instruction sequencing and decode unit for the LC-3 datapath: a Moore FSM that issues every load enable, bus gate, mux select and memory strobe for one instruction at a time.
- It sequences the condition-code/branch-enable unit: it asserts LD_CC on register writebacks and LD_BEN at decode, then reads BEN back to choose the branch path.
- Sits between the top-level Run/Continue switches, the IR fields and the datapath/SRAM interface.

Parameters:
- MEM_WAIT, 2, number of cycles Mem_OE/Mem_WE stay asserted per memory access (≥1).
- CNT_W, 2, width of the wait counter; must satisfy 2^CNT_W > MEM_WAIT.

Ports:
- Clk  in  1  system clock, all state changes on rising edge.
- Reset  in  1  asynchronous, active-high; forces state Halted.
- Run  in  1  start execution (level, sampled in Halted).
- Continue  in  1  resume from PAUSE (level).
- Opcode  in  4  IR[15:12].
- IR_5  in  1  IR[5], immediate select.
- IR_11  in  1  IR[11]; 1=JSR, 0=JSRR.
- BEN  in  1  registered branch enable from CC unit.
- LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED  out  1 each  register load enables.
- GatePC, GateMDR, GateALU, GateMARMUX  out  1 each  bus drivers; at most one high per cycle.
- PCMUX  out  2  00=PC+1, 01=bus, 10=address adder.
- DRMUX  out  1  0=IR[11:9], 1=R7.
- SR1MUX  out  1  0=IR[11:9], 1=IR[8:6].
- SR2MUX  out  1  0=register, 1=SEXT(imm5).
- ADDR1MUX  out  1  0=PC, 1=SR1.
- ADDR2MUX  out  2  00=0, 01=SEXT(off6), 10=SEXT(off9), 11=SEXT(off11).
- ALUK  out  2  00=ADD, 01=AND, 10=NOT, 11=PASS A.
- Mem_OE, Mem_WE  out  1 each  SRAM read/write strobes, active-high.

Behaviour:
- Outputs are pure functions of the registered state. Every output defaults to 0 in every state not listed below, including after reset.
- Reset is asynchronous and active-high: state ← Halted and the wait counter ← 0 immediately, including mid-instruction and mid-access.
- Halted: leave for S18 only when Run=1.
- S18 (LD_MAR, GatePC, LD_PC, PCMUX=00) → S33.
- S33 (Mem_OE): stays for exactly MEM_WAIT cycles, then → S35. The counter clears on entry and on exit.
- S35 (GateMDR, LD_IR) → S32.
- S32 (LD_BEN) decodes Opcode:
  - 0001 → S01
  - 0101 → S05
  - 1001 → S09
  - 0000 → S00
  - 1100 → S12
  - 0100 → S04
  - 0110 → S06
  - 0111 → S07
  - 1101 → PauseIR1
  - any other opcode → S18 (treated as NOP).
- S01 (SR1MUX=1, SR2MUX=IR_5, ALUK=00, GateALU, LD_REG, LD_CC) → S18.
- S05: same as S01 with ALUK=01 → S18.
- S09 (SR1MUX=1, ALUK=10, GateALU, LD_REG, LD_CC) → S18.
- S00: no outputs. BEN=1 → S22, else → S18. BEN is the value updated by the LD_BEN issued in S32, one cycle earlier.
- S22 (ADDR1MUX=0, ADDR2MUX=10, PCMUX=10, LD_PC) → S18.
- S12 (SR1MUX=1, ADDR1MUX=1, ADDR2MUX=00, PCMUX=10, LD_PC) → S18.
- S04 (GatePC, DRMUX=1, LD_REG) → S21 if IR_11=1, else S20. LD_CC is not asserted.
- S21 (ADDR1MUX=0, ADDR2MUX=11, PCMUX=10, LD_PC) → S18.
- S20: same as S12 → S18.
- S06 (SR1MUX=1, ADDR1MUX=1, ADDR2MUX=01, GateMARMUX, LD_MAR) → S25.
- S25 (Mem_OE, LD_MDR): held for MEM_WAIT cycles → S27.
- S27 (GateMDR, LD_REG, LD_CC) → S18.
- S07: same as S06 → S23.
- S23 (SR1MUX=0, ALUK=11, GateALU, LD_MDR) → S16.
- S16 (Mem_WE): held for MEM_WAIT cycles → S18.
- PauseIR1 (LD_LED): stay while Continue=0; → PauseIR2 when Continue=1.
- PauseIR2: stay while Continue=1; → S18 when Continue=0. One Continue press therefore resumes exactly once.
- Run deasserting after leaving Halted has no effect. Only Reset returns the FSM to Halted.
- Invariant: at most one Gate* output is high in any state. LD_CC is asserted only in S01, S05, S09 and S27.

Test Plan:
- Reset asserted mid-S33 with Run=1 → all outputs 0 within the same cycle. After Reset release with Run=0, the FSM stays Halted 10 cycles. Run=1 → S18 next edge, with LD_MAR=GatePC=LD_PC=1.
- Fetch timing, MEM_WAIT=2: Mem_OE high exactly 2 cycles. LD_IR on cycle 4 after S18, LD_BEN on cycle 5.
- Opcode=0000 with BEN=1 → S22 with LD_PC=1, PCMUX=10, ADDR2MUX=10. Repeat with BEN=0 → S18 directly and LD_PC never asserted.
- Opcode=0001, IR_5=1 → one cycle with SR2MUX=1, GateALU=LD_REG=LD_CC=1, then back to S18.
- Opcode=0111 (STR) → LD_MAR, then LD_MDR with ALUK=11, then Mem_WE high for MEM_WAIT cycles, with no LD_CC anywhere. Opcode=0110 (LDR) → LD_CC in its final state.
- Opcode=1101 → LD_LED held while Continue=0. Continue held high 5 cycles → FSM waits in PauseIR2 and does not refetch. Continue low → S18 next cycle.
- Opcode=0100, IR_11=1 → DRMUX=1 with LD_REG, then ADDR2MUX=11 PC load.
